// File: rtl/s_counter_pkg.sv
// s_counter_pkg
// Shared definitions for the JK-based counter family.
//   - jk_mode_e : {J,K} drive codes for a single JK cell
//   - W_MIN/W_MAX : legal counter width range
//   - jkLoad() : {J,K} code that forces a cell to a given bit value
package s_counter_pkg;

  localparam int W_MIN = 2;
  localparam int W_MAX = 16;

  typedef enum logic [1:0] {
    JK_HOLD   = 2'b00,
    JK_RESET  = 2'b01,
    JK_SET    = 2'b10,
    JK_TOGGLE = 2'b11
  } jk_mode_e;

  // A parallel load is a set or a reset per bit, never a toggle.
  function automatic jk_mode_e jkLoad(input logic b);
    return b ? JK_SET : JK_RESET;
  endfunction

endpackage

// File: rtl/s_up_counter_if.sv
// s_up_counter_if
// Control/status bundle of one up-counter stage.
//   master : drives en, load, d, tc_val; observes L, tc, co, wrap
//   slave  : the counter itself
// Parameter W must match the W of the counter that the bundle is connected to.
interface s_up_counter_if #(parameter int W = 4);

  logic         en;
  logic         load;
  logic [W-1:0] d;
  logic [W-1:0] tc_val;
  logic [W-1:0] L;
  logic         tc;
  logic         co;
  logic         wrap;

  modport master (output en, load, d, tc_val, input L, tc, co, wrap);
  modport slave  (input en, load, d, tc_val, output L, tc, co, wrap);

endinterface

// File: rtl/s_up_counter_jk_ff_sr.sv
// jk_ff_sr
// Single JK flip-flop with synchronous active-low reset.
// Ports:
//   clk   in  clock, rising edge
//   rst_n in  synchronous reset, active low (Q=0, NQ=1)
//   J, K  in  JK drive: 00 hold, 01 reset, 10 set, 11 toggle
//   Q     out stored bit
//   NQ    out complement of Q
module jk_ff_sr
  import s_counter_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic J,
  input  logic K,
  output logic Q,
  output logic NQ
);

  logic r_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_q <= 1'b0;
    end else begin
      case ({J, K})
        JK_HOLD:   r_q <= r_q;
        JK_RESET:  r_q <= 1'b0;
        JK_SET:    r_q <= 1'b1;
        JK_TOGGLE: r_q <= ~r_q;
        default:   r_q <= r_q;
      endcase
    end
  end

  // NQ is derived from the single stored bit so the pair can never disagree.
  assign Q  = r_q;
  assign NQ = ~r_q;

endmodule

// File: rtl/s_up_counter.sv
// s_up_counter
// Synchronous up counter built from W JK cells. The top level only steers
// J/K per bit, compares against the terminal count and registers wrap.
// Ports:
//   clk         in  clock, rising edge
//   rst_n       in  synchronous reset, active low
//   bus.en      in  count enable
//   bus.load    in  parallel load strobe (beats en)
//   bus.d       in  parallel load value
//   bus.tc_val  in  terminal count; counter restarts after this value
//   bus.L       out counter value (JK Q outputs)
//   bus.tc      out combinational, L == tc_val
//   bus.co      out combinational carry, tc & en, feeds next stage en
//   bus.wrap    out registered pulse in the cycle L has just restarted to 0
// Build option:
//   S_UP_COUNTER_SATURATE_EN  - when defined the counter holds at the limit
//                               instead of restarting, and wrap never asserts.
module s_up_counter
  import s_counter_pkg::*;
#(
  parameter int W = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  s_up_counter_if.slave  bus
);

`ifdef S_UP_COUNTER_SATURATE_EN
  localparam logic [1:0] LIMIT_MODE    = JK_HOLD;
  localparam logic       WRAP_ON_LIMIT = 1'b0;
`else
  localparam logic [1:0] LIMIT_MODE    = JK_RESET;
  localparam logic       WRAP_ON_LIMIT = 1'b1;
`endif

  logic [W-1:0] w_q;
  logic [W-1:0] w_nq;
  logic [W-1:0] w_j;
  logic [W-1:0] w_k;
  logic [W-1:0] w_carry;
  logic [1:0]   w_jk [W];
  logic         w_tc;
  logic         w_atLimit;
  logic         r_wrap;

  assign w_tc = (w_q == bus.tc_val);
  // All ones is read from the NQ side: every NQ low means every Q high.
  assign w_atLimit = w_tc | ~(|w_nq);

  // Toggle chain: a bit flips when every lower bit is already 1.
  assign w_carry[0] = 1'b1;
  for (genvar gi = 1; gi < W; gi++) begin : g_carry
    assign w_carry[gi] = &w_q[gi-1:0];
  end

  always_comb begin
    for (int i = 0; i < W; i++) begin
      w_jk[i] = JK_HOLD;
      if (!rst_n) begin
        w_jk[i] = JK_RESET;
      end else if (bus.load) begin
        w_jk[i] = jkLoad(bus.d[i]);
      end else if (bus.en) begin
        if (w_atLimit) begin
          w_jk[i] = LIMIT_MODE;
        end else begin
          w_jk[i] = w_carry[i] ? JK_TOGGLE : JK_HOLD;
        end
      end
    end
  end

  for (genvar gi = 0; gi < W; gi++) begin : g_cell
    assign w_j[gi] = w_jk[gi][1];
    assign w_k[gi] = w_jk[gi][0];

    jk_ff_sr u_cell (
      .clk   (clk),
      .rst_n (rst_n),
      .J     (w_j[gi]),
      .K     (w_k[gi]),
      .Q     (w_q[gi]),
      .NQ    (w_nq[gi])
    );
  end

  // wrap marks the cycle after a count-restart; load and hold never pulse it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wrap <= 1'b0;
    end else begin
      r_wrap <= WRAP_ON_LIMIT & ~bus.load & bus.en & w_atLimit;
    end
  end

  assign bus.L    = w_q;
  assign bus.tc   = w_tc;
  assign bus.co   = w_tc & bus.en;
  assign bus.wrap = r_wrap;

endmodule

// File: tb/tb_s_up_counter.sv
// tb_s_up_counter
// Scoreboard bench for s_up_counter (W=4): stimulus pushes the expected
// post-edge outputs, an independent monitor pops and compares after each
// edge. A second pair of counters is cascaded through co.
// Honours S_UP_COUNTER_SATURATE_EN in its reference model.
module tb_s_up_counter;

  localparam int TB_W = 4;
  localparam int MAXV = (1 << TB_W) - 1;

  typedef struct {
    int l;
    bit wrap;
    bit tc;
    bit co;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic casRstN;

  exp_t expQ[$];
  int   checks = 0;
  int   errors = 0;
  int   modelL = 0;

  always #5 clk = ~clk;

  s_up_counter_if #(.W(TB_W)) bus   ();
  s_up_counter_if #(.W(TB_W)) loBus ();
  s_up_counter_if #(.W(TB_W)) hiBus ();

  s_up_counter #(.W(TB_W)) dut   (.clk(clk), .rst_n(rst_n),   .bus(bus));
  s_up_counter #(.W(TB_W)) casLo (.clk(clk), .rst_n(casRstN), .bus(loBus));
  s_up_counter #(.W(TB_W)) casHi (.clk(clk), .rst_n(casRstN), .bus(hiBus));

  assign hiBus.en = loBus.co;

  // Reference: next value from the priority rules with plain arithmetic.
  function automatic void stepModel(input int curL, input bit rstN, input bit en,
                                    input bit ld, input int dv, input int tcv,
                                    output int nL, output bit nWrap);
    nL    = curL;
    nWrap = 1'b0;
    if (!rstN) begin
      nL = 0;
    end else if (ld) begin
      nL = dv;
    end else if (en) begin
      if (curL == tcv || curL == MAXV) begin
`ifdef S_UP_COUNTER_SATURATE_EN
        nL = curL;
`else
        nL    = 0;
        nWrap = 1'b1;
`endif
      end else begin
        nL = curL + 1;
      end
    end
  endfunction

  task automatic checkOutput(input string name, input logic [15:0] got, input int expv);
    checks++;
    if (got !== expv[15:0]) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, got, expv);
    end
  endtask

  task automatic applyStimulus(input bit rstN, input bit en, input bit ld,
                               input int dv, input int tcv);
    int   nL;
    bit   nW;
    exp_t e;
    @(negedge clk);
    rst_n      = rstN;
    bus.en     = en;
    bus.load   = ld;
    bus.d      = dv[TB_W-1:0];
    bus.tc_val = tcv[TB_W-1:0];
    stepModel(modelL, rstN, en, ld, dv, tcv, nL, nW);
    modelL = nL;
    e.l    = nL;
    e.wrap = nW;
    e.tc   = (nL == tcv);
    e.co   = e.tc & en;
    expQ.push_back(e);
  endtask

  // Monitor: every edge the DUT presents a new value; compare it if expected.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput("L",    16'(bus.L),    e.l);
        checkOutput("wrap", 16'(bus.wrap), int'(e.wrap));
        checkOutput("tc",   16'(bus.tc),   int'(e.tc));
        checkOutput("co",   16'(bus.co),   int'(e.co));
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected $finish");
    $fatal(1, "[TB] time limit");
  end

  initial begin
    int curTc;
    int cL, cH, nLo, nHi;
    bit wLo, wHi, hiEn;

    rst_n        = 1'b0;
    bus.en       = 1'b0;
    bus.load     = 1'b0;
    bus.d        = '0;
    bus.tc_val   = '0;
    casRstN      = 1'b0;
    loBus.en     = 1'b1;
    loBus.load   = 1'b0;
    loBus.d      = '0;
    loBus.tc_val = 4'd15;
    hiBus.load   = 1'b0;
    hiBus.d      = '0;
    hiBus.tc_val = 4'd15;

    // Reset for two edges, then a full mod-16 run.
    repeat (2) applyStimulus(0, 1, 0, 0, 15);
    repeat (17) applyStimulus(1, 1, 0, 0, 15);

    // Modulo 10 from zero.
    applyStimulus(0, 0, 0, 0, 9);
    repeat (12) applyStimulus(1, 1, 0, 0, 9);

    // Load beats en at L=3, then run past a smaller tc_val.
    applyStimulus(1, 1, 0, 0, 9);
    applyStimulus(1, 1, 1, 12, 9);
    repeat (4) applyStimulus(1, 1, 0, 0, 5);

    // Hold at 7, then reset while at terminal count 9 with en high.
    applyStimulus(1, 0, 1, 7, 9);
    repeat (3) applyStimulus(1, 0, 0, 0, 9);
    applyStimulus(1, 1, 0, 0, 9);
    applyStimulus(1, 1, 0, 0, 9);
    applyStimulus(0, 1, 0, 0, 9);

    // Limit at 6 (restart or saturate depending on build), then load 2.
    repeat (10) applyStimulus(1, 1, 0, 0, 6);
    applyStimulus(1, 1, 1, 2, 6);

    // tc_val == 0.
    applyStimulus(0, 0, 0, 0, 0);
    repeat (4) applyStimulus(1, 1, 0, 0, 0);

    // Random traffic.
    curTc = 9;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 19) == 0) curTc = $urandom_range(0, MAXV);
      applyStimulus($urandom_range(0, 49) != 0, $urandom_range(0, 3) != 0,
                    $urandom_range(0, 9) == 0, $urandom_range(0, MAXV), curTc);
    end

    repeat (2) @(negedge clk);
    checkOutput("queueEmpty", 16'(expQ.size()), 0);

    // Cascade: low stage co drives high stage en.
    @(negedge clk);
    checkOutput("cascadeReset", {8'd0, hiBus.L, loBus.L}, 0);
    casRstN = 1'b1;
    cL = 0;
    cH = 0;
    for (int i = 0; i < 40; i++) begin
      hiEn = (cL == 15);
      stepModel(cL, 1, 1, 0, 0, 15, nLo, wLo);
      stepModel(cH, 1, hiEn, 0, 0, 15, nHi, wHi);
      cL = nLo;
      cH = nHi;
      @(posedge clk);
      #1;
      checkOutput("cascade", {8'd0, hiBus.L, loBus.L}, cH * 16 + cL);
      @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
